// File: rtl/rf_read_arbiter.sv
// rtl/rf_read_arbiter.sv - four-requester round-robin arbiter for the 64-bit register-file read mux
module rf_read_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req_valid,
  input  logic [19:0] req_addr,
  output logic [3:0]  req_ready,
  output logic [4:0]  sel,
  input  logic [63:0] mux_data,
  output logic [3:0]  rsp_valid,
  output logic [63:0] rsp_data,
  input  logic [3:0]  rsp_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  ptr;
  logic [1:0]  gnt;
  logic [1:0]  gnt_idx;
  logic [1:0]  cand;
  logic        gnt_found;
  logic        accept;
  logic        rsp_hs;
  logic [4:0]  slot_addr [4];

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      slot_addr[k] = req_addr[5*k +: 5];
    end
  end

  // Round-robin search: first requesting slot at or after ptr, wrapping mod 4.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = ptr;
    cand      = ptr;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_found) state_nxt = READ;
      READ:    state_nxt = RESP;
      RESP:    if (rsp_ready[gnt]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // req_ready is gated by reset so it reads zero while reset is held low.
  always_comb begin
    req_ready = 4'b0000;
    accept    = 1'b0;
    rsp_hs    = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_found && reset) begin
          req_ready[gnt_idx] = 1'b1;
          accept             = 1'b1;
        end
      end
      RESP: rsp_hs = rsp_ready[gnt];
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr       <= 2'd0;
      gnt       <= 2'd0;
      sel       <= 5'd0;
      rsp_valid <= 4'b0000;
      rsp_data  <= 64'h0;
    end else begin
      if (accept) begin
        sel <= slot_addr[gnt_idx];
        gnt <= gnt_idx;
      end
      // Register 31 is the hard-wired zero register; the mux output is ignored.
      if (state == READ) begin
        rsp_data  <= (sel == 5'd31) ? 64'h0 : mux_data;
        rsp_valid <= 4'b0001 << gnt;
      end
      if (rsp_hs) begin
        rsp_valid <= 4'b0000;
        ptr       <= gnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_rf_read_arbiter.sv
// tb/tb_rf_read_arbiter.sv - directed self-checking bench for rf_read_arbiter
module tb_rf_read_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [19:0] req_addr;
  logic [3:0]  req_ready;
  logic [4:0]  sel;
  logic [63:0] mux_data;
  logic [3:0]  rsp_valid;
  logic [63:0] rsp_data;
  logic [3:0]  rsp_ready;

  logic [4:0]  addr [4];
  logic [63:0] mem [32];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign req_addr = {addr[3], addr[2], addr[1], addr[0]};
  assign mux_data = mem[sel];

  rf_read_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .sel       (sel),
    .mux_data  (mux_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready)
  );

  task test_reset;
    reset = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 4'b0000;
    #12;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready got=%b want=0000", req_ready); end
    total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0000", rsp_valid); end
    total++; if (sel !== 5'd0) begin bad++; $display("FAIL reset_sel got=%0d want=0", sel); end
    total++; if (rsp_data !== 64'h0) begin bad++; $display("FAIL reset_rsp_data got=%h want=0", rsp_data); end
    @(negedge clk);
    reset = 1'b1;
    req_valid = 4'b0000;
  endtask

  task test_single_read;
    @(negedge clk);
    addr[2] = 5'd6;
    mem[6] = 64'hA5;
    req_valid = 4'b0100;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_req_ready got=%b want=0100", req_ready); end
    @(negedge clk); #1;
    total++; if (sel !== 5'd6) begin bad++; $display("FAIL single_sel got=%0d want=6", sel); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL single_ready_in_read got=%b want=0000", req_ready); end
    @(negedge clk); #1;
    total++; if (rsp_valid !== 4'b0100) begin bad++; $display("FAIL single_rsp_valid got=%b want=0100", rsp_valid); end
    total++; if (rsp_data !== 64'hA5) begin bad++; $display("FAIL single_rsp_data got=%h want=a5", rsp_data); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL single_ready_in_resp got=%b want=0000", req_ready); end
    rsp_ready = 4'b0100;
    req_valid = 4'b0000;
    @(negedge clk);
    rsp_ready = 4'b0000;
    #1;
    total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL single_rsp_cleared got=%b want=0000", rsp_valid); end
    total++; if (rsp_data !== 64'hA5) begin bad++; $display("FAIL single_data_kept got=%h want=a5", rsp_data); end
  endtask

  task test_zero_reg;
    @(negedge clk);
    addr[0] = 5'd31;
    mem[31] = 64'hFFFF_FFFF_FFFF_FFFF;
    req_valid = 4'b0001;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL zero_req_ready got=%b want=0001", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    total++; if (sel !== 5'd31) begin bad++; $display("FAIL zero_sel got=%0d want=31", sel); end
    @(negedge clk);
    rsp_ready = 4'b1110;
    #1;
    total++; if (rsp_valid !== 4'b0001) begin bad++; $display("FAIL zero_rsp_valid got=%b want=0001", rsp_valid); end
    total++; if (rsp_data !== 64'h0) begin bad++; $display("FAIL zero_rsp_data got=%h want=0", rsp_data); end
    @(negedge clk); #1;
    total++; if (rsp_valid !== 4'b0001) begin bad++; $display("FAIL zero_other_ready_ignored got=%b want=0001", rsp_valid); end
    rsp_ready = 4'b0001;
    @(negedge clk);
    rsp_ready = 4'b0000;
    #1;
    total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL zero_rsp_cleared got=%b want=0000", rsp_valid); end
  endtask

  task test_fairness;
    int g;
    logic [3:0] exp_oh;
    logic [63:0] exp_data;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) addr[i] = 5'(i + 1);
    req_valid = 4'b1111;
    rsp_ready = 4'b1111;
    for (int c = 0; c < 15; c++) begin
      #1;
      g = (c / 3) % 4;
      exp_oh = 4'b0001 << g;
      exp_data = 64'hDEAD_0000_0000_0000 | 64'(g + 1);
      if (c % 3 == 0) begin
        total++; if (req_ready !== exp_oh) begin bad++; $display("FAIL fair_grant c=%0d got=%b want=%b", c, req_ready, exp_oh); end
      end else if (c % 3 == 1) begin
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL fair_gap c=%0d got=%b want=0000", c, req_ready); end
        total++; if (sel !== 5'(g + 1)) begin bad++; $display("FAIL fair_sel c=%0d got=%0d want=%0d", c, sel, g + 1); end
      end else begin
        total++; if (rsp_valid !== exp_oh) begin bad++; $display("FAIL fair_rsp_valid c=%0d got=%b want=%b", c, rsp_valid, exp_oh); end
        total++; if (rsp_data !== exp_data) begin bad++; $display("FAIL fair_rsp_data c=%0d got=%h want=%h", c, rsp_data, exp_data); end
      end
      @(negedge clk);
    end
    req_valid = 4'b0000;
    rsp_ready = 4'b0000;
  endtask

  task test_backpressure;
    @(negedge clk);
    addr[2] = 5'd9;
    addr[3] = 5'd13;
    mem[9] = 64'h99;
    req_valid = 4'b0100;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL bp_grant got=%b want=0100", req_ready); end
    @(negedge clk);
    req_valid = 4'b1011;
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready_in_read got=%b want=0000", req_ready); end
    @(negedge clk); #1;
    total++; if (rsp_valid !== 4'b0100) begin bad++; $display("FAIL bp_rsp_valid got=%b want=0100", rsp_valid); end
    total++; if (rsp_data !== 64'h99) begin bad++; $display("FAIL bp_rsp_data got=%h want=99", rsp_data); end
    mem[9] = 64'h77;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      total++; if (rsp_valid !== 4'b0100) begin bad++; $display("FAIL bp_hold_valid i=%0d got=%b want=0100", i, rsp_valid); end
      total++; if (rsp_data !== 64'h99) begin bad++; $display("FAIL bp_hold_data i=%0d got=%h want=99", i, rsp_data); end
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_hold_ready i=%0d got=%b want=0000", i, req_ready); end
    end
    rsp_ready = 4'b0100;
    @(negedge clk);
    rsp_ready = 4'b0000;
    #1;
    total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL bp_rsp_cleared got=%b want=0000", rsp_valid); end
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL bp_resume_grant got=%b want=1000", req_ready); end
  endtask

  task test_reset_mid_read;
    @(negedge clk); #1;
    total++; if (sel !== 5'd13) begin bad++; $display("FAIL mid_sel_before got=%0d want=13", sel); end
    reset = 1'b0;
    #1;
    total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL mid_rsp_valid got=%b want=0000", rsp_valid); end
    total++; if (sel !== 5'd0) begin bad++; $display("FAIL mid_sel got=%0d want=0", sel); end
    total++; if (rsp_data !== 64'h0) begin bad++; $display("FAIL mid_rsp_data got=%h want=0", rsp_data); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL mid_req_ready got=%b want=0000", req_ready); end
    rsp_ready = 4'b1111;
    @(negedge clk);
    reset = 1'b1;
    req_valid = 4'b0000;
    @(negedge clk); #1;
    total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL mid_no_response got=%b want=0000", rsp_valid); end
    req_valid = 4'b1001;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL mid_ptr_zero got=%b want=0001", req_ready); end
    req_valid = 4'b1000;
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL mid_regrant got=%b want=1000", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    total++; if (sel !== 5'd13) begin bad++; $display("FAIL mid_regrant_sel got=%0d want=13", sel); end
    @(negedge clk); #1;
    total++; if (rsp_valid !== 4'b1000) begin bad++; $display("FAIL mid_regrant_valid got=%b want=1000", rsp_valid); end
    total++; if (rsp_data !== 64'hDEAD_0000_0000_000D) begin bad++; $display("FAIL mid_regrant_data got=%h want=dead00000000000d", rsp_data); end
    @(negedge clk);
    rsp_ready = 4'b0000;
  endtask

  initial begin
    for (int k = 0; k < 32; k++) mem[k] = 64'hDEAD_0000_0000_0000 | 64'(k);
    for (int i = 0; i < 4; i++) addr[i] = 5'd0;
    req_valid = 4'b0000;
    rsp_ready = 4'b0000;
    test_reset();
    test_single_read();
    test_zero_reg();
    test_fairness();
    test_backpressure();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
